// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave that frames FRAME_BITS-bit words onto a valid/ready receive port.
// Define SPI_SLAVE_FRAME_TX_EN to build the MISO response path (buffer + tx shifter).
module spi_slave_frame #(
  parameter int FRAME_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_MOSI,
  input  logic                  SPI_CS,
  output logic                  SPI_MISO,
  output logic [FRAME_BITS-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic [FRAME_BITS-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT_CNT  = CW'(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclk_sync, mosi_sync, cs_sync, flush;
  logic                    sclk_prev, cs_prev, cs_armed;
  logic [CW-1:0]           bit_cnt;
  logic [FRAME_BITS-1:0]   rx_shift;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, cs_fall, cs_rise, frame_start;

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign cs_fall     = ~cs_s & cs_prev;
  assign cs_rise     = cs_s & ~cs_prev;
  assign frame_start = (state == IDLE) & cs_fall & cs_armed;

  // The flush chain marks when the synchronizers hold real pin values again after reset;
  // a frame is only armed once CS has been seen high, so a CS held low through reset is ignored.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      flush     <= '0;
      cs_armed  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      if (flush[SYNC_STAGES-1] && cs_s)
        cs_armed <= 1'b1;
    end
  end

  // The end-of-frame decision is taken on the SHIFT->DONE transition so its registered
  // results (m_valid, frame_err, overrun) are visible during the DONE cycle itself.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (m_valid && m_ready)
        m_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= DONE;
            if (bit_cnt != FULL_CNT) begin
              frame_err <= 1'b1;
            end else if (!m_valid || m_ready) begin
              m_data  <= rx_shift;
              m_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt != SAT_CNT)
              bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_FRAME_TX_EN
  logic [FRAME_BITS-1:0] tx_shift, tx_buf;
  logic                  buf_full, miso_q, sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_prev;
  assign s_ready   = flush[0] & ~buf_full;
  assign SPI_MISO  = miso_q;

  // A load in the same cycle as frame start wins, so the new word waits for the next frame.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      tx_shift <= '0;
      tx_buf   <= '0;
      buf_full <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        tx_shift <= buf_full ? tx_buf : '0;
        miso_q   <= buf_full & tx_buf[FRAME_BITS-1];
        buf_full <= 1'b0;
      end else if (state == SHIFT) begin
        if (cs_rise) begin
          miso_q <= 1'b0;
        end else if (sclk_fall) begin
          tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
          miso_q   <= tx_shift[FRAME_BITS-2];
        end
      end
      if (s_valid && s_ready) begin
        tx_buf   <= s_data;
        buf_full <= 1'b1;
      end
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{s_data, s_valid};
  assign SPI_MISO  = 1'b0;
  assign s_ready   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Scoreboard bench for spi_slave_frame: stimulus queues expected receive events, a monitor
// pops them as m_valid rises or frame_err/overrun pulse. Expectations follow SPI_SLAVE_FRAME_TX_EN.
module tb_spi_slave_frame;

`ifdef SPI_SLAVE_FRAME_TX_EN
  localparam bit TX_BUILD = 1'b1;
`else
  localparam bit TX_BUILD = 1'b0;
`endif

  localparam int EV_DATA = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, sclk, mosi, cs, miso;
  logic [31:0] m_data, s_data;
  logic        m_valid, m_ready, s_valid, s_ready, frame_err, overrun;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cs_rise_cyc = 0;
  int          mv_rise_cyc = 0;
  int          mv_width = 0;
  logic        mv_prev = 1'b0;
  logic        miso_seen = 1'b0;
  logic [31:0] miso_word;

  spi_slave_frame #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .SPI_SCLK       (sclk),
    .SPI_MOSI       (mosi),
    .SPI_CS         (cs),
    .SPI_MISO       (miso),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .frame_err      (frame_err),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic popEvent(input int kind, input logic [31:0] data);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_event actual_kind=%0d data=%h expected=none", kind, data);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || (kind == EV_DATA && e.data !== data)) begin
        errors++;
        $display("[TB] FAIL event actual_kind=%0d data=%h expected_kind=%0d data=%h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: consumes expected events when the DUT presents them
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_valid && !mv_prev) begin
        mv_rise_cyc = cyc;
        popEvent(EV_DATA, m_data);
      end
      if (!m_valid && mv_prev) mv_width = cyc - mv_rise_cyc;
      if (frame_err) popEvent(EV_FERR, 32'h0);
      if (overrun) popEvent(EV_OVR, 32'h0);
      if (miso !== 1'b0) miso_seen = 1'b1;
    end
    mv_prev = m_valid;
  end

  task automatic pushExp(input int kind, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    expq.push_back(e);
  endtask

  // Master: mode 0, samples MISO just before each SCLK rise; optionally leaves CS low
  task automatic applyStimulus(input logic [31:0] word, input int nbits, input bit end_cs,
                               output logic [31:0] rx_miso);
    rx_miso = '0;
    @(negedge clk) cs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? word[31-i] : 1'b0;
      repeat (2) @(negedge clk);
      if (i < 32) rx_miso = {rx_miso[30:0], miso};
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (end_cs) begin
      cs = 1'b1;
      cs_rise_cyc = cyc;
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cs      = 1'b1;
    m_ready = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    s_valid = TX_BUILD ? 1'b0 : 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_m_valid", {31'b0, m_valid}, 32'h0);
    checkOutput("rst_m_data", m_data, 32'h0);
    checkOutput("rst_miso", {31'b0, miso}, 32'h0);
    checkOutput("rst_s_ready", {31'b0, s_ready}, 32'h0);
    checkOutput("rst_pulses", {30'b0, frame_err, overrun}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("s_ready_after_rst", {31'b0, s_ready}, {31'b0, TX_BUILD});

    $display("[TB] basic frame with m_ready high");
    pushExp(EV_DATA, 32'hA5C3_0F81);
    applyStimulus(32'hA5C3_0F81, 32, 1'b1, miso_word);
    checkOutput("valid_latency", mv_rise_cyc - cs_rise_cyc, 32'd3);
    checkOutput("valid_width", mv_width, 32'd1);
    checkOutput("miso_empty_buf", miso_word, 32'h0);

    $display("[TB] response word on MISO");
    if (TX_BUILD) begin
      s_data  = 32'h1234_ABCD;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("s_ready_loaded", {31'b0, s_ready}, 32'h0);
    pushExp(EV_DATA, 32'h0F0F_0F0F);
    applyStimulus(32'h0F0F_0F0F, 32, 1'b1, miso_word);
    checkOutput("miso_word", miso_word, TX_BUILD ? 32'h1234_ABCD : 32'h0);
    checkOutput("s_ready_drained", {31'b0, s_ready}, {31'b0, TX_BUILD});
    pushExp(EV_DATA, 32'h3C3C_3C3C);
    applyStimulus(32'h3C3C_3C3C, 32, 1'b1, miso_word);
    checkOutput("miso_no_load", miso_word, 32'h0);
    checkOutput("m_data_3c", m_data, 32'h3C3C_3C3C);

    $display("[TB] overrun with m_ready low");
    m_ready = 1'b0;
    pushExp(EV_DATA, 32'h1111_1111);
    applyStimulus(32'h1111_1111, 32, 1'b1, miso_word);
    pushExp(EV_OVR, 32'h0);
    applyStimulus(32'h2222_2222, 32, 1'b1, miso_word);
    checkOutput("overrun_data_kept", m_data, 32'h1111_1111);
    checkOutput("overrun_valid_held", {31'b0, m_valid}, 32'h1);
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("valid_released", {31'b0, m_valid}, 32'h0);

    $display("[TB] short and long frames");
    pushExp(EV_FERR, 32'h0);
    applyStimulus(32'hFFFF_FFFF, 31, 1'b1, miso_word);
    pushExp(EV_FERR, 32'h0);
    applyStimulus(32'h8000_0001, 33, 1'b1, miso_word);
    checkOutput("ferr_m_data_kept", m_data, 32'h1111_1111);

    $display("[TB] reset mid-frame");
    applyStimulus(32'hCAFE_F00D, 16, 1'b0, miso_word);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_m_data", m_data, 32'h0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    pushExp(EV_DATA, 32'h0000_FFFF);
    applyStimulus(32'h0000_FFFF, 32, 1'b1, miso_word);
    checkOutput("post_rst_m_data", m_data, 32'h0000_FFFF);

    repeat (20) @(negedge clk);
    checkOutput("events_left", expq.size(), 32'd0);
    if (!TX_BUILD) checkOutput("miso_stuck_zero", {31'b0, miso_seen}, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
SPI_SLAVE_FRAME -- requirements
Module: spi_slave_frame

Interface
REQ-001 Parameter FRAME_BITS, default 32, SHALL set the number of bits in one SPI frame (legal range 8..32).
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth on SPI_SCLK, SPI_MOSI and SPI_CS (legal range 2..3).
REQ-003 s00_axi_aclk  in  1  SHALL be the single system clock; every flop uses its rising edge.
REQ-004 s00_axi_aresetn  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 SPI_SCLK  in  1  SHALL be the serial clock from the SPI master, mode 0 (CPOL=0, CPHA=0).
REQ-006 SPI_MOSI  in  1  SHALL be serial data from the master, MSB first.
REQ-007 SPI_CS  in  1  SHALL be the active-low frame select.
REQ-008 SPI_MISO  out  1  SHALL be serial response data to the master, MSB first.
REQ-009 m_data  out  FRAME_BITS  SHALL be the received frame word.
REQ-010 m_valid / m_ready  out / in  1 each  SHALL form the receive-word handshake.
REQ-011 s_data  in  FRAME_BITS  SHALL be the response word for the next frame.
REQ-012 s_valid / s_ready  in / out  1 each  SHALL form the response-word handshake.
REQ-013 frame_err  out  1  SHALL pulse one cycle when a frame ends with a bit count other than FRAME_BITS.
REQ-014 overrun  out  1  SHALL pulse one cycle when a complete frame is dropped.

Function
REQ-015 SCLK, MOSI and CS SHALL pass through SYNC_STAGES flops, then one edge-detect register; all decisions use the synchronized copies.
REQ-016 The block SHALL support s00_axi_aclk >= 8x SCLK; faster SCLK is out of scope.
REQ-017 FSM states: IDLE, SHIFT, DONE.
REQ-018 IDLE -> SHIFT on synchronized CS falling edge: clear bit counter, load tx shift register.
REQ-019 In SHIFT, on each synchronized SCLK rising edge the block SHALL shift MOSI into the LSB of rx shift register and increment a saturating bit counter (saturates at FRAME_BITS+1).
REQ-020 In SHIFT, on each synchronized SCLK falling edge the tx shift register SHALL shift left and SPI_MISO SHALL present the new MSB.
REQ-021 SHIFT -> DONE on synchronized CS rising edge; DONE -> IDLE the next cycle unconditionally.
REQ-022 In DONE with bit count == FRAME_BITS: if m_valid is low, or m_ready is high in that cycle, load m_data and assert m_valid; otherwise keep the old m_data and pulse overrun.
REQ-023 In DONE with bit count != FRAME_BITS: pulse frame_err, leave m_data/m_valid unchanged.
REQ-024 Latency: m_valid SHALL rise exactly 1 cycle after the cycle the edge detector flags CS rising.
REQ-025 m_valid SHALL stay high with m_data stable until a cycle with m_valid & m_ready; it deasserts the following cycle unless REQ-022 reloads it in that cycle.
REQ-026 s_ready SHALL be high when the one-entry response buffer is empty; s_valid & s_ready loads s_data into it.
REQ-027 At frame start (REQ-018) a full buffer SHALL be moved to the tx shift register and emptied; an empty buffer loads all zeros.
REQ-028 A buffer load and a frame-start consume in the same cycle SHALL leave the new word in the buffer.
REQ-029 SPI_MISO SHALL drive the tx MSB in SHIFT and 0 in IDLE and DONE.
REQ-030 SCLK edges while CS is high SHALL be ignored.

Reset
REQ-031 Reset SHALL asynchronously force: FSM IDLE, synchronizers to CS=1/SCLK=0/MOSI=0, counters and shift registers 0, response buffer empty.
REQ-032 Output reset values: SPI_MISO 0, m_data 0, m_valid 0, s_ready 0 during reset (1 from first cycle after release), frame_err 0, overrun 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; after release a frame is only accepted after a new CS falling edge.

Configuration
REQ-034 Macro SPI_SLAVE_FRAME_TX_EN defined: response path (buffer, tx shift register, REQ-020, REQ-026..029) is present.
REQ-035 Macro SPI_SLAVE_FRAME_TX_EN undefined: no response logic, SPI_MISO tied 0, s_ready tied 0, s_data/s_valid ignored; receive path unchanged.

Verification (FRAME_BITS=32, SYNC_STAGES=2, clk 100 MHz, SCLK 10 MHz)
REQ-036 Frame MOSI 0xA5C3_0F81, m_ready=1 -> m_data=0xA5C30F81, m_valid high exactly one cycle, 1 cycle after CS-rise flag.
REQ-037 s_data=0x1234_ABCD loaded before CS fall -> master captures 0x1234ABCD on MISO; next frame without load -> 0x00000000.
REQ-038 Two frames 0x11111111 then 0x22222222 with m_ready=0 -> m_data stays 0x11111111, overrun pulses once, frame_err 0.
REQ-039 Frame of 31 clocks, then 33 clocks -> frame_err pulses after each, m_valid never asserts.
REQ-040 Assert s00_axi_aresetn low after 16 bits, release, send full frame 0x0000FFFF -> only 0x0000FFFF delivered, no frame_err.
REQ-041 Build without SPI_SLAVE_FRAME_TX_EN, s_valid=1 -> SPI_MISO constant 0, s_ready 0, REQ-036 still passes.
